// File: rtl/mem_arbiter.sv
// Purpose: lets two bus masters (m0 cpu, m1 aux) share one single-port word-addressed RAM.
// Latency: the request goes to the RAM in the grant cycle; the one-cycle ready pulse follows RAM_LATENCY cycles later.
// Backpressure: each master holds its request until it sees ready; requests that arrive while busy wait for the next IDLE.
module mem_arbiter #(
    parameter int RAM_LATENCY = 1,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_re,
    input  logic [3:0]  m0_we,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic [29:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_re,
    input  logic [3:0]  m1_we,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_re,
    output logic [3:0]  ram_we,
    input  logic [31:0] ram_dout,
    output logic [1:0]  grant
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(RAM_LATENCY - 1);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;   // 0 = m0, 1 = m1
    logic       last_q,  last_d;
    logic [1:0] cnt_q,   cnt_d;

    logic m0_req, m1_req, win;

    always_comb begin
        m0_req = m0_re | (|m0_we);
        m1_req = m1_re | (|m1_we);
        // On a round-robin tie the winner is whichever master did not win last.
        win    = (m1_req & ~m0_req) |
                 (m0_req & m1_req & ~FIXED_PRIO & ~last_q);
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        m0_rdata = 32'd0;
        m0_ready = 1'b0;
        m1_rdata = 32'd0;
        m1_ready = 1'b0;
        ram_addr = 30'd0;
        ram_din  = 32'd0;
        ram_re   = 1'b0;
        ram_we   = 4'd0;
        grant    = 2'b00;

        // While reset is held, every output is forced quiet, including a WAIT that is being abandoned.
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (m0_req | m1_req) begin
                        ram_addr = win ? m1_addr  : m0_addr;
                        ram_din  = win ? m1_wdata : m0_wdata;
                        ram_re   = win ? m1_re    : m0_re;
                        ram_we   = win ? m1_we    : m0_we;
                        grant    = win ? 2'b10    : 2'b01;
                        state_d  = WAIT;
                        owner_d  = win;
                        last_d   = win;
                        cnt_d    = CNT_INIT;
                    end
                end
                WAIT: begin
                    grant = owner_q ? 2'b10 : 2'b01;
                    if (cnt_q != 2'd0) begin
                        cnt_d = cnt_q - 2'd1;
                    end else begin
                        state_d = IDLE;
                        if (owner_q) begin
                            m1_ready = 1'b1;
                            m1_rdata = ram_dout;
                        end else begin
                            m0_ready = 1'b1;
                            m0_rdata = ram_dout;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
